// File: rtl/regfile_arb_pkg.sv
// ============================================================================
// Module      : regfile_arb_pkg
// Description : Shared types and constants for the register-file port
//               arbiter: arbitration state encoding, default widths and
//               the architectural zero-register index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_arb_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int REG_ZERO       = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_port_mux.sv
// ============================================================================
// Module      : regfile_port_mux
// Description : Combinational source select for the regfile ports. The core
//               drives the ports unless the debug access slot is active;
//               in the ack slot the core write enable is suppressed.
//               Optional macro REGFILE_ARB_R0_GUARD_EN blocks every write to
//               register 0 regardless of source.
// Ports       : i_sel_dbg        - debug owns write port and read port A
//               i_gate_core_we   - suppress core write enable
//               i_core_*         - core writeback / read addresses
//               i_dbg_*          - debug write fields and target register
//               o_wr_*, o_rd_*   - regfile port drives
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_port_mux
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  i_sel_dbg,
    input  logic                  i_gate_core_we,
    input  logic                  i_core_we,
    input  logic [REG_ADDR_W-1:0] i_core_wreg,
    input  logic [DATA_W-1:0]     i_core_wdata,
    input  logic [REG_ADDR_W-1:0] i_core_rA,
    input  logic [REG_ADDR_W-1:0] i_core_rB,
    input  logic                  i_dbg_we,
    input  logic [REG_ADDR_W-1:0] i_dbg_reg,
    input  logic [DATA_W-1:0]     i_dbg_wdata,
    output logic                  o_wr_en,
    output logic [REG_ADDR_W-1:0] o_wr_reg,
    output logic [DATA_W-1:0]     o_wr_data,
    output logic [REG_ADDR_W-1:0] o_rd_regA,
    output logic [REG_ADDR_W-1:0] o_rd_regB
);

    logic w_we_raw;

    assign w_we_raw  = i_sel_dbg ? i_dbg_we    : (i_core_we & ~i_gate_core_we);
    assign o_wr_reg  = i_sel_dbg ? i_dbg_reg   : i_core_wreg;
    assign o_wr_data = i_sel_dbg ? i_dbg_wdata : i_core_wdata;
    assign o_rd_regA = i_sel_dbg ? i_dbg_reg   : i_core_rA;
    // Port B is never borrowed; the core keeps reading through it.
    assign o_rd_regB = i_core_rB;

`ifdef REGFILE_ARB_R0_GUARD_EN
    assign o_wr_en = w_we_raw & (o_wr_reg != REG_ADDR_W'(REG_ZERO));
`else
    assign o_wr_en = w_we_raw;
`endif

endmodule

`default_nettype wire

// File: rtl/regfile_port_arbiter.sv
// ============================================================================
// Module      : regfile_port_arbiter
// Description : Shares the register file between the core and a debug
//               requester. A debug request stalls the core, lets one
//               in-flight writeback drain, then performs one regfile access
//               per req/ack handshake, with at most MAX_BURST back-to-back
//               accesses before a forced unstalled core cycle.
//               Optional macro REGFILE_ARB_R0_GUARD_EN (in regfile_port_mux)
//               suppresses writes to register 0.
// Ports       : clock/reset       - clock, async active-high reset
//               core_*            - core writeback, read addresses, stall
//               dbg_*             - debug req/ack handshake and data
//               ctrl_*/data_*     - regfile port connections
//               err_drop          - sticky dropped-core-write flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  core_we,
    input  logic [REG_ADDR_W-1:0] core_wreg,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [REG_ADDR_W-1:0] core_rA,
    input  logic [REG_ADDR_W-1:0] core_rB,
    output logic                  core_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [REG_ADDR_W-1:0] dbg_reg,
    input  logic [DATA_W-1:0]     dbg_wdata,
    output logic                  dbg_ack,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  ctrl_writeEnable,
    output logic [REG_ADDR_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0]     data_writeReg,
    output logic [REG_ADDR_W-1:0] ctrl_readRegA,
    output logic [REG_ADDR_W-1:0] ctrl_readRegB,
    input  logic [DATA_W-1:0]     data_readRegA,
    output logic                  err_drop
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              r_core_stall;
    logic              r_dbg_ack;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic              r_err_drop;
    logic              w_in_access;
    logic              w_in_done;

    assign w_in_access = (r_state == ACCESS);
    assign w_in_done   = (r_state == DONE);
    assign w_cnt_inc   = r_cnt + CNT_W'(1);

    // The burst limit is checked against the count including the access
    // just acknowledged, so exactly MAX_BURST acks precede the forced IDLE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (dbg_req) w_next = DRAIN;
            DRAIN:   w_next = ACCESS;
            ACCESS:  w_next = DONE;
            DONE:    w_next = (dbg_req && (w_cnt_inc < CNT_W'(MAX_BURST))) ? ACCESS : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Stall and ack are decoded from the next state so they are registered
    // yet aligned with the state they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_core_stall <= 1'b0;
            r_dbg_ack    <= 1'b0;
            r_dbg_rdata  <= '0;
            r_err_drop   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_core_stall <= (w_next != IDLE);
            r_dbg_ack    <= (w_next == DONE);
            if (w_in_access) begin
                r_dbg_rdata <= data_readRegA;
            end
            if ((w_in_access || w_in_done) && core_we) begin
                r_err_drop <= 1'b1;
            end
            if (w_in_done) begin
                r_cnt <= (w_next == ACCESS) ? w_cnt_inc : '0;
            end
        end
    end

    regfile_port_mux #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_mux (
        .i_sel_dbg      (w_in_access),
        .i_gate_core_we (w_in_done),
        .i_core_we      (core_we),
        .i_core_wreg    (core_wreg),
        .i_core_wdata   (core_wdata),
        .i_core_rA      (core_rA),
        .i_core_rB      (core_rB),
        .i_dbg_we       (dbg_we),
        .i_dbg_reg      (dbg_reg),
        .i_dbg_wdata    (dbg_wdata),
        .o_wr_en        (ctrl_writeEnable),
        .o_wr_reg       (ctrl_writeReg),
        .o_wr_data      (data_writeReg),
        .o_rd_regA      (ctrl_readRegA),
        .o_rd_regB      (ctrl_readRegB)
    );

    assign core_stall = r_core_stall;
    assign dbg_ack    = r_dbg_ack;
    assign dbg_rdata  = r_dbg_rdata;
    assign err_drop   = r_err_drop;

endmodule

`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
// ============================================================================
// Module      : tb_regfile_port_arbiter
// Description : Directed self-checking bench for regfile_port_arbiter with a
//               behavioural register file attached to the regfile ports.
//               Honors REGFILE_ARB_R0_GUARD_EN for the register-0 step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          core_we;
    logic [AW-1:0] core_wreg;
    logic [DW-1:0] core_wdata;
    logic [AW-1:0] core_rA;
    logic [AW-1:0] core_rB;
    logic          core_stall;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_reg;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic          ctrl_writeEnable;
    logic [AW-1:0] ctrl_writeReg;
    logic [DW-1:0] data_writeReg;
    logic [AW-1:0] ctrl_readRegA;
    logic [AW-1:0] ctrl_readRegB;
    logic [DW-1:0] data_readRegA;
    logic          err_drop;

    logic [DW-1:0] rf [32];
    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] ackv;
    logic [15:0] stallv;

    always #5 clock = ~clock;

    regfile_port_arbiter #(.DATA_W(DW), .REG_ADDR_W(AW), .MAX_BURST(4)) dut (
        .clock(clock), .reset(reset),
        .core_we(core_we), .core_wreg(core_wreg), .core_wdata(core_wdata),
        .core_rA(core_rA), .core_rB(core_rB), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_reg(dbg_reg), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .ctrl_readRegA(ctrl_readRegA),
        .ctrl_readRegB(ctrl_readRegB), .data_readRegA(data_readRegA),
        .err_drop(err_drop)
    );

    // Behavioural regfile: synchronous write, combinational read on port A.
    always @(posedge clock) begin
        if (ctrl_writeEnable) rf[ctrl_writeReg] <= data_writeReg;
    end
    assign data_readRegA = rf[ctrl_readRegA];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        reset = 1'b1; core_we = 1'b0; core_wreg = '0; core_wdata = '0;
        core_rA = 5'd3; core_rB = 5'd4;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_reg = '0; dbg_wdata = '0;
        tick();
        tick();

        // Reset state and pass-through
        chk("rst_stall", 32'(core_stall), 32'd0);
        chk("rst_ack",   32'(dbg_ack),    32'd0);
        chk("rst_rdata", dbg_rdata,       32'd0);
        chk("rst_err",   32'(err_drop),   32'd0);
        chk("rst_rdA",   32'(ctrl_readRegA), 32'd3);
        chk("rst_rdB",   32'(ctrl_readRegB), 32'd4);
        core_we = 1'b1; core_wreg = 5'd9; core_wdata = 32'h0000_00AA;
        #1;
        chk("rst_we",    32'(ctrl_writeEnable), 32'd1);
        chk("rst_wreg",  32'(ctrl_writeReg), 32'd9);
        core_we = 1'b0;
        reset = 1'b0;
        tick();

        // Debug write r5 = DEADBEEF
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_reg = 5'd5; dbg_wdata = 32'hDEAD_BEEF;
        tick();
        chk("wr_c1_stall", 32'(core_stall), 32'd1);
        chk("wr_c1_ack",   32'(dbg_ack),    32'd0);
        tick();
        chk("wr_c2_stall", 32'(core_stall), 32'd1);
        chk("wr_c2_we",    32'(ctrl_writeEnable), 32'd1);
        chk("wr_c2_wreg",  32'(ctrl_writeReg), 32'd5);
        chk("wr_c2_rdA",   32'(ctrl_readRegA), 32'd5);
        chk("wr_c2_rdB",   32'(ctrl_readRegB), 32'd4);
        tick();
        chk("wr_c3_ack",   32'(dbg_ack),    32'd1);
        chk("wr_c3_stall", 32'(core_stall), 32'd1);
        chk("wr_c3_old",   dbg_rdata,       32'd0);
        dbg_req = 1'b0;
        tick();
        chk("wr_c4_stall", 32'(core_stall), 32'd0);
        chk("wr_c4_ack",   32'(dbg_ack),    32'd0);

        // Debug read r5
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_reg = 5'd5;
        tick();
        chk("rd_c1_stall", 32'(core_stall), 32'd1);
        tick();
        chk("rd_c2_ack",   32'(dbg_ack),    32'd0);
        tick();
        chk("rd_c3_ack",   32'(dbg_ack),    32'd1);
        chk("rd_c3_data",  dbg_rdata,       32'hDEAD_BEEF);
        dbg_req = 1'b0;
        tick();
        chk("rd_c4_stall", 32'(core_stall), 32'd0);

        // Request together with a core writeback that lands during DRAIN
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_reg = 5'd1;
        tick();
        core_we = 1'b1; core_wreg = 5'd1; core_wdata = 32'd65535;
        #1;
        chk("drn_stall", 32'(core_stall), 32'd1);
        chk("drn_we",    32'(ctrl_writeEnable), 32'd1);
        tick();
        core_we = 1'b0;
        tick();
        chk("drn_ack",   32'(dbg_ack), 32'd1);
        chk("drn_data",  dbg_rdata, 32'd65535);
        chk("drn_err",   32'(err_drop), 32'd0);
        dbg_req = 1'b0;
        tick();

        // Held request, 6 reads, MAX_BURST=4
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_reg = 5'd5;
        ackv = '0; stallv = '0;
        for (int k = 1; k < 16; k++) begin
            tick();
            ackv[k]   = dbg_ack;
            stallv[k] = core_stall;
            if (k == 15) dbg_req = 1'b0;
        end
        chk("burst_acks",  32'(ackv),   32'h0000_A2A8);
        chk("burst_stall", 32'(stallv), 32'h0000_FBFE);
        chk("burst_data",  dbg_rdata,   32'hDEAD_BEEF);
        tick();
        chk("burst_end",   32'(core_stall), 32'd0);

        // Core write dropped during ACCESS/DONE
        core_we = 1'b1; core_wreg = 5'd2; core_wdata = 32'h11;
        tick();
        core_we = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_reg = 5'd2;
        tick();
        tick();
        core_we = 1'b1; core_wreg = 5'd2; core_wdata = 32'd7;
        #1;
        chk("drop_acc_we", 32'(ctrl_writeEnable), 32'd0);
        chk("drop_acc_rA", 32'(ctrl_readRegA), 32'd2);
        tick();
        chk("drop_done_we", 32'(ctrl_writeEnable), 32'd0);
        chk("drop_data",    dbg_rdata, 32'h11);
        chk("drop_err",     32'(err_drop), 32'd1);
        core_we = 1'b0; dbg_req = 1'b0;
        tick();
        dbg_req = 1'b1;
        tick(); tick(); tick();
        chk("drop_reread", dbg_rdata, 32'h11);
        chk("drop_err_hold", 32'(err_drop), 32'd1);
        dbg_req = 1'b0;
        tick();

        // Reset in the middle of a debug write
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_reg = 5'd6; dbg_wdata = 32'h55;
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        chk("mrst_stall", 32'(core_stall), 32'd0);
        chk("mrst_ack",   32'(dbg_ack), 32'd0);
        chk("mrst_err",   32'(err_drop), 32'd0);
        dbg_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("mrst_post_stall", 32'(core_stall), 32'd0);
        chk("mrst_post_ack",   32'(dbg_ack), 32'd0);
        chk("mrst_no_commit",  rf[6], 32'd0);

        // Register-0 debug write
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_reg = 5'd0; dbg_wdata = 32'h1234;
        tick(); tick();
`ifdef REGFILE_ARB_R0_GUARD_EN
        chk("r0_we", 32'(ctrl_writeEnable), 32'd0);
`else
        chk("r0_we", 32'(ctrl_writeEnable), 32'd1);
`endif
        tick();
        chk("r0_ack", 32'(dbg_ack), 32'd1);
        dbg_req = 1'b0;
        tick();
        dbg_req = 1'b1; dbg_we = 1'b0;
        tick(); tick(); tick();
`ifdef REGFILE_ARB_R0_GUARD_EN
        chk("r0_read", dbg_rdata, 32'd0);
`else
        chk("r0_read", dbg_rdata, 32'h1234);
`endif
        dbg_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Shares the processor register file between the core's decode/writeback ports and a debug/test requester. The core owns the ports by default. A debug request stalls the core, drains one in-flight writeback, then gives the requester one regfile access per grant with a req/ack handshake. The block sits between the core, the regfile and the skeleton-level test mux, and replaces ad hoc `test`-signal muxing.

## Interface
- DATA_W, 32, regfile data width
- REG_ADDR_W, 5, regfile address width
- MAX_BURST, 4, maximum consecutive debug accesses before one forced core cycle (≥1)

- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- core_we, core_wreg, core_wdata  in  1/REG_ADDR_W/DATA_W  core writeback port
- core_rA, core_rB  in  REG_ADDR_W  core read addresses
- core_stall  out  1  registered; core must freeze its pipeline while high
- dbg_req  in  1  debug request, level
- dbg_we  in  1  1 = write, 0 = read
- dbg_reg  in  REG_ADDR_W  debug target register
- dbg_wdata  in  DATA_W  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_W  registered read data, valid with dbg_ack, held until the next ack
- ctrl_writeEnable, ctrl_writeReg, data_writeReg  out  1/REG_ADDR_W/DATA_W  to regfile write port
- ctrl_readRegA, ctrl_readRegB  out  REG_ADDR_W  to regfile read ports
- data_readRegA  in  DATA_W  regfile port A data (combinational read)
- err_drop  out  1  sticky: a core write was dropped during ACCESS

## Operation
- States: IDLE, DRAIN, ACCESS, DONE. Reset enters IDLE.
- IDLE: all regfile ports pass through from core. If dbg_req=1, go to DRAIN.
- DRAIN: core_stall=1, core still routed, so its last in-flight writeback lands. Always go to ACCESS.
- ACCESS:
  - Write port is driven from dbg_we/dbg_reg/dbg_wdata.
  - ctrl_readRegA=dbg_reg.
  - ctrl_readRegB still follows core_rB.
  - dbg_rdata captures data_readRegA at the end of the cycle, for both reads and writes (a write returns the old value).
  - Go to DONE.
- DONE: dbg_ack=1, core routed with core_we gated to 0. Burst counter increments.
  - If dbg_req=1 and count<MAX_BURST, go to ACCESS.
  - Otherwise go to IDLE and clear the counter.
- A forced IDLE cycle after MAX_BURST guarantees the core at least one unstalled cycle. The next request then re-enters via DRAIN.
- Requester handshake:
  - Holds dbg_req, dbg_we, dbg_reg and dbg_wdata stable from assertion until dbg_ack.
  - Fields are sampled only in ACCESS.
  - To chain transactions, keep dbg_req high and present new fields in the cycle after dbg_ack.
- Dropping dbg_req before ack is a protocol violation. The access still completes.
- core_we=1 during ACCESS or DONE: the write is dropped and err_drop is set. err_drop is cleared only by reset.

## Timing
- Reset values:
  - State IDLE, burst counter 0.
  - core_stall=0, dbg_ack=0, dbg_rdata=0, err_drop=0.
  - Regfile outputs follow the core inputs (combinational pass-through).
- core_stall=1 in DRAIN, ACCESS and DONE. It is a registered decode of the state.
- Latency:
  - dbg_req seen high at edge 0 gives DRAIN in cycle 1, ACCESS in cycle 2, and dbg_ack in cycle 3.
  - Back-to-back throughput is one access per 2 cycles.
- The regfile write commits at the rising edge that ends ACCESS.
- Reset asserted mid-transaction aborts it immediately: state goes to IDLE with no ack. A write already committed is not undone.

## Configuration
- REGFILE_ARB_R0_GUARD_EN
  - Defined: ctrl_writeEnable is forced to 0 whenever the selected write register is 0, for both core and debug sources. dbg_ack still pulses.
  - Undefined: register-0 writes pass to the regfile unchanged, and r0 protection is left to the regfile.

## Structure
- Shared package regfile_arb_pkg holds:
  - the state enum (IDLE, DRAIN, ACCESS, DONE);
  - DATA_W and REG_ADDR_W defaults;
  - localparam REG_ZERO=0.
- One sub-module, regfile_port_mux: the combinational core/debug source select plus the r0 guard. The FSM, burst counter, dbg_rdata register and err_drop live in regfile_port_arbiter.

## Test plan
- Reset mid-ACCESS, dbg_we=1 → state IDLE, no dbg_ack, core_stall=0 the cycle after reset deasserts.
- Debug write r5=0xDEADBEEF, then debug read r5 → second dbg_ack carries dbg_rdata=0xDEADBEEF; core_stall high for cycles 1-3 of each transaction.
- dbg_req asserted the same cycle as core_we=1 to r1=65535 → the DRAIN-cycle write lands, and a debug read r1 returns 65535.
- dbg_req held high for 6 reads with MAX_BURST=4 → acks at cycles 3, 5, 7, 9; core_stall low for one cycle after the 4th ack; remaining acks follow via DRAIN.
- core_we=1 to r2=7 during ACCESS → r2 unchanged (debug read returns the prior value) and err_drop=1 until reset.
- With REGFILE_ARB_R0_GUARD_EN, debug write r0=0x1234 → ctrl_writeEnable stays 0, dbg_ack pulses, and a read of r0 returns 0.
